vga_scan_gen: RTL

- Pixel-scan source for the display pipeline: the producer end of the pixelX/pixelY -> draw/RGB interface that every object renderer consumes.
- Free-running horizontal/vertical counters produce pixel coordinates and a frame-start pulse for the renderers.
- Accepts the merged 8-bit RGB332 colour back from the object mux.
- Emits aligned 4:4:4 VGA colour plus hsync/vsync, delayed to match renderer latency.

---
 rtl/vga_scan_gen_pkg.sv | 64 ++++++
 rtl/vga_scan_gen_sync_delay.sv | 34 +++
 rtl/vga_scan_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_scan_gen_pkg.sv
// Shared VGA timing defaults, colour types and colour helpers for the scan generator.
package vga_scan_gen_pkg;

  // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_PIPE_LAT  = 2;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned COORD_MAX = (1 << COORD_W) - 1;

  localparam logic [7:0] COLOR_DEFAULT = 8'h00;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
  } scan_ctl_t;

  localparam scan_ctl_t CTL_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Widen by repeating the MSB so full-scale 3-bit values reach 4'hF.
  function automatic rgb444_t expand_rgb332(input rgb332_t c);
    rgb444_t o;
    o.r = {c.r, c.r[2]};
    o.g = {c.g, c.g[2]};
    o.b = {c.b, c.b};
    return o;
  endfunction

  function automatic rgb332_t bar_color(input logic [2:0] idx);
    rgb332_t c;
    case (idx)
      3'd0:    c = 8'hFF;  // white
      3'd1:    c = 8'hFC;  // yellow
      3'd2:    c = 8'h1F;  // cyan
      3'd3:    c = 8'h1C;  // green
      3'd4:    c = 8'hE3;  // magenta
      3'd5:    c = 8'hE0;  // red
      3'd6:    c = 8'h03;  // blue
      default: c = 8'h00;  // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_gen_sync_delay.sv
// Fixed-depth shift register with a programmable reset value; DEPTH=0 is a wire.
module sync_delay #(
  parameter int unsigned          DEPTH     = 1,
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = clk ^ reset;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RESET_VAL;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: pixel counters, raw syncs, latency-matched colour/sync outputs.
// Define VGA_TEST_PATTERN_EN to replace RGBIn with an internal 8-bar colour pattern.
module vga_scan_gen
  import vga_scan_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned PIPE_LAT  = VGA_PIPE_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        visible,
  output logic        startOfFrame,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSync,
  output logic        vSync
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_scan_gen: H_TOTAL/V_TOTAL must not exceed 2047");
  end
  if (PIPE_LAT > 7) begin : g_bad_lat
    $error("vga_scan_gen: PIPE_LAT must be in 0..7");
  end

  // ---------------- counters ----------------
  logic [10:0] x_reg, x_next;
  logic [10:0] y_reg, y_next;

  always_comb begin
    x_next = x_reg + 11'd1;
    y_next = y_reg;
    if (x_reg == H_LAST) begin
      x_next = '0;
      y_next = (y_reg == V_LAST) ? 11'd0 : y_reg + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
    end
  end

  assign pixelX  = x_reg;
  assign pixelY  = y_reg;
  assign visible = (x_reg < H_VIS_END) && (y_reg < V_VIS_END);
  // Gated by reset so the pulse only appears once the counters are live.
  assign startOfFrame = (x_reg == 11'd0) && (y_reg == 11'd0) && !reset;

  // ---------------- raw sync and alignment ----------------
  scan_ctl_t ctl_raw;
  scan_ctl_t ctl_dly;

  always_comb begin
    ctl_raw.visible = visible;
    ctl_raw.hsync   = !((x_reg >= HS_START) && (x_reg < HS_END));
    ctl_raw.vsync   = !((y_reg >= VS_START) && (y_reg < VS_END));
  end

  sync_delay #(
    .DEPTH     (PIPE_LAT),
    .WIDTH     (3),
    .RESET_VAL (CTL_IDLE)
  ) u_ctl_delay (
    .clk   (clk),
    .reset (reset),
    .din   (ctl_raw),
    .dout  (ctl_dly)
  );

  // ---------------- colour source ----------------
  rgb332_t pix_color;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_VISIBLE / 8;

  logic [6:0] bar_ge;
  logic [2:0] bar_idx;
  rgb332_t    bar_src;
  logic       unused_rgb;

  // Thermometer of bar boundaries; its popcount is the bar index.
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    assign bar_ge[gi-1] = (x_reg >= 11'(gi * BAR_W));
  end

  assign bar_idx    = 3'($countones(bar_ge));
  assign bar_src    = bar_color(bar_idx);
  assign unused_rgb = ^RGBIn;

  // Pattern is generated from the live counters, so it must take the same
  // delay the renderers impose on RGBIn.
  sync_delay #(
    .DEPTH     (PIPE_LAT),
    .WIDTH     (8),
    .RESET_VAL (COLOR_DEFAULT)
  ) u_bar_delay (
    .clk   (clk),
    .reset (reset),
    .din   (bar_src),
    .dout  (pix_color)
  );
`else
  assign pix_color = RGBIn;
`endif

  // ---------------- output register ----------------
  rgb444_t color_reg, color_next;
  logic    hsync_reg;
  logic    vsync_reg;

  always_comb begin
    color_next = expand_rgb332(COLOR_DEFAULT);
    if (ctl_dly.visible) color_next = expand_rgb332(pix_color);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      color_reg <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
    end else begin
      color_reg <= color_next;
      hsync_reg <= ctl_dly.hsync;
      vsync_reg <= ctl_dly.vsync;
    end
  end

  assign red   = color_reg.r;
  assign green = color_reg.g;
  assign blue  = color_reg.b;
  assign hSync = hsync_reg;
  assign vSync = vsync_reg;

endmodule
